// File: rtl/dbg_uart_port.sv
// rtl/dbg_uart_port.sv - memory-mapped debug UART: byte FIFO feeding an 8N1 serializer
// Registers at BASE: DATA (+0), STATUS (+2), reserved (+4, +6).
module dbg_uart_port #(
  parameter logic [15:0] BASE    = 16'hFF00,
  parameter int          DEPTH   = 4,
  parameter int          DIVISOR = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] dread_addr,
  output logic [15:0] dread_data,
  output logic        dread_hit,
  input  logic [15:0] dwrite_addr,
  input  logic [15:0] dwrite_data,
  input  logic [1:0]  dwrite_en,
  output logic        txd,
  output logic        tx_busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int DW = $clog2(DIVISOR);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [DW-1:0] DIV_LAST = DW'(DIVISOR - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state, state_nxt;
  logic [DW-1:0] div_cnt, div_nxt;
  logic [2:0]    bit_cnt, bit_nxt;
  logic [7:0]    shift, shift_nxt;
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count, count_nxt;
  logic          overflow;
  logic          pop;

  logic       w_hit, r_hit;
  logic [1:0] w_off, r_off;
  logic       push_req, push, full, clr_ovf;
  logic [15:0] status, rd_val;

  assign w_hit    = (dwrite_addr[15:3] == BASE[15:3]);
  assign w_off    = dwrite_addr[2:1];
  assign r_hit    = (dread_addr[15:3] == BASE[15:3]);
  assign r_off    = dread_addr[2:1];
  assign full     = (count == FULL_CNT);
  assign push_req = w_hit && (w_off == 2'd0) && dwrite_en[0];
  assign push     = push_req && !full;
  assign clr_ovf  = w_hit && (w_off == 2'd1) && dwrite_en[0] && dwrite_data[2];

  assign status = {8'(count), 4'b0000, (state != IDLE), overflow, (count == '0), !full};

  always_comb begin
    rd_val = 16'h0000;
    if (r_hit && (r_off == 2'd1)) rd_val = status;
  end

  always_comb begin
    count_nxt = count;
    case ({push, pop})
      2'b10:   count_nxt = count + (AW+1)'(1);
      2'b01:   count_nxt = count - (AW+1)'(1);
      default: count_nxt = count;
    endcase
  end

  // The head byte is loaded into the shift register on the same edge it is popped.
  always_comb begin
    state_nxt = state;
    div_nxt   = div_cnt;
    bit_nxt   = bit_cnt;
    shift_nxt = shift;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        if (count != '0) begin
          pop       = 1'b1;
          shift_nxt = mem[rd_ptr];
          div_nxt   = '0;
          state_nxt = START;
        end
      end
      START: begin
        if (div_cnt == DIV_LAST) begin
          div_nxt   = '0;
          bit_nxt   = 3'd0;
          state_nxt = DATA;
        end else begin
          div_nxt = div_cnt + DW'(1);
        end
      end
      DATA: begin
        if (div_cnt == DIV_LAST) begin
          div_nxt   = '0;
          shift_nxt = {1'b0, shift[7:1]};
          if (bit_cnt == 3'd7) state_nxt = STOP;
          else                 bit_nxt   = bit_cnt + 3'd1;
        end else begin
          div_nxt = div_cnt + DW'(1);
        end
      end
      STOP: begin
        if (div_cnt == DIV_LAST) begin
          div_nxt = '0;
          if (count != '0) begin
            pop       = 1'b1;
            shift_nxt = mem[rd_ptr];
            state_nxt = START;
          end else begin
            state_nxt = IDLE;
          end
        end else begin
          div_nxt = div_cnt + DW'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= dwrite_data[7:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      div_cnt    <= '0;
      bit_cnt    <= 3'd0;
      shift      <= 8'h00;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      overflow   <= 1'b0;
      tx_busy    <= 1'b0;
      dread_data <= 16'h0000;
      dread_hit  <= 1'b0;
    end else begin
      state      <= state_nxt;
      div_cnt    <= div_nxt;
      bit_cnt    <= bit_nxt;
      shift      <= shift_nxt;
      count      <= count_nxt;
      tx_busy    <= (state_nxt != IDLE) || (count_nxt != '0);
      dread_data <= rd_val;
      dread_hit  <= r_hit;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      // Full is judged on the pre-edge count, so a same-cycle pop does not rescue the byte.
      if (push_req && full) overflow <= 1'b1;
      else if (clr_ovf)     overflow <= 1'b0;
    end
  end

  always_comb begin
    txd = 1'b1;
    case (state)
      START:   txd = 1'b0;
      DATA:    txd = shift[0];
      default: txd = 1'b1;
    endcase
  end

endmodule
